// File: rtl/key_event_fifo_pkg.sv
// Shared constants for the monitor keyboard path: FIFO geometry, the decoder's
// "unmapped key" code and a few ASCII codes used by the display logic.
package key_event_fifo_pkg;

    localparam logic [7:0] KEY_INVALID    = 8'hFF;
    localparam int         KEY_FIFO_DEPTH = 8;
    localparam int         KEY_FIFO_AW    = 3;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    // An event is only worth storing if the decoder mapped the key.
    function automatic logic code_is_mapped(input logic [7:0] code, input logic [7:0] invalid);
        return (code != invalid);
    endfunction

endpackage

// File: rtl/key_event_fifo_if.sv
// Valid/ready event stream from the key FIFO to the display/monitor logic.
interface key_event_fifo_if #(
    parameter int W = 8
);
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/key_event_fifo_sync_fifo_sa.sv
// Generic single-clock show-ahead FIFO; the head entry is visible on dout
// without a read strobe, and reads as zero while empty.
module key_event_fifo_sync_fifo_sa #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          pop_ok_s;
    logic          push_ok_s;

    // Qualify requests so a stray pop on empty or push on full is ignored.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (level_r != {(AW+1){1'b0}}) begin
            pop_ok_s = pop;
        end else begin
            pop_ok_s = 1'b0;
        end
        push_ok_s = push & ((level_r != FULL_LEVEL) | pop_ok_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks dout.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem[wr_ptr_r] <= din;
    end

    assign empty = (level_r == {(AW+1){1'b0}});
    assign full  = (level_r == FULL_LEVEL);
    assign level = level_r;
    assign dout  = empty ? {W{1'b0}} : mem[rd_ptr_r];

endmodule

// File: rtl/key_event_fifo.sv
// Turns each new key press from the PS/2 decoder into one buffered event,
// filtering unmapped codes and flagging drops with a sticky overflow bit.
module key_event_fifo
    import key_event_fifo_pkg::*;
#(
    parameter int         DEPTH        = KEY_FIFO_DEPTH,
    parameter int         ADDR_W       = KEY_FIFO_AW,
    parameter logic [7:0] INVALID_CODE = KEY_INVALID
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        key_code,
    input  logic              key_state,
    key_event_fifo_if.master  bus,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              clr_ovf
);

    logic key_state_d_r;
    logic rise_d_r;
    logic overflow_r;
    logic rise_s;
    logic push_req_s;
    logic pop_s;
    logic push_s;
    logic drop_s;
    logic full_s;
    logic empty_s;

    // Event qualification; key_code is sampled a cycle after the rise because
    // the decoder's ASCII register trails its key-held flag by one cycle.
    always_comb begin
        rise_s     = key_state & ~key_state_d_r;
        push_req_s = rise_d_r & code_is_mapped(key_code, INVALID_CODE);
        pop_s      = ~empty_s & bus.out_ready;
        push_s     = push_req_s & (~full_s | pop_s);
        drop_s     = push_req_s & full_s & ~pop_s;
    end

    // Edge detector pipeline; typematic repeats keep key_state high, so no new rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_state_d_r <= 1'b0;
            rise_d_r      <= 1'b0;
        end else begin
            key_state_d_r <= key_state;
            rise_d_r      <= rise_s;
        end
    end

    // Sticky overflow; a drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    key_event_fifo_sync_fifo_sa #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (key_code),
        .dout  (bus.out_data),
        .level (level),
        .full  (full_s),
        .empty (empty_s)
    );

    assign bus.out_valid = ~empty_s;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: press/hold, ordering, filtering, overflow,
// full-with-pop and asynchronous reset, with hand-computed expectations.
module tb_key_event_fifo;
    import key_event_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_state = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] level;
    logic       overflow;
    int         checks = 0;
    int         errors = 0;

    key_event_fifo_if bus ();

    key_event_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_state (key_state),
        .bus       (bus),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // key_state rises after edge N, key_code follows one cycle later, push at N+2.
    task automatic press(input logic [7:0] code);
        key_state = 1'b1;
        step();
        key_code = code;
        step();
        key_state = 1'b0;
        step();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        #25;
        check("reset_valid", 16'(bus.out_valid), 16'h0);
        check("reset_data", 16'(bus.out_data), 16'h00);
        check("reset_level", 16'(level), 16'h0);
        check("reset_ovf", 16'(overflow), 16'h0);
        rst = 1'b1;
        step();
        step();

        // Single press and long hold
        key_state = 1'b1;
        step();
        check("no_early_valid", 16'(bus.out_valid), 16'h0);
        key_code = ASCII_A;
        step();
        check("press_valid", 16'(bus.out_valid), 16'h1);
        check("press_data", 16'(bus.out_data), 16'h41);
        check("press_level", 16'(level), 16'h1);
        repeat (1000) step();
        check("hold_level", 16'(level), 16'h1);
        key_state = 1'b0;
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("pop_one_level", 16'(level), 16'h0);

        // Ordering of three events
        press(8'h51);
        press(8'h57);
        press(8'h45);
        check("three_level", 16'(level), 16'h3);
        bus.out_ready = 1'b1;
        check("order_0", 16'(bus.out_data), 16'h51);
        step();
        check("order_1", 16'(bus.out_data), 16'h57);
        step();
        check("order_2", 16'(bus.out_data), 16'h45);
        step();
        check("drained_valid", 16'(bus.out_valid), 16'h0);
        check("drained_level", 16'(level), 16'h0);
        step();
        step();
        bus.out_ready = 1'b0;
        check("empty_pop_level", 16'(level), 16'h0);

        // Unmapped key is filtered
        press(8'hFF);
        check("invalid_level", 16'(level), 16'h0);
        check("invalid_ovf", 16'(overflow), 16'h0);

        // Nine presses into eight slots
        for (int i = 0; i < 9; i++) press(8'h61 + 8'(i));
        check("full_level", 16'(level), 16'h8);
        check("full_ovf", 16'(overflow), 16'h1);
        check("full_head", 16'(bus.out_data), 16'h61);

        // Drop coinciding with clr_ovf: set wins
        key_state = 1'b1;
        step();
        key_code = 8'h7A;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        key_state = 1'b0;
        step();
        check("drop_vs_clr_ovf", 16'(overflow), 16'h1);
        check("drop_vs_clr_level", 16'(level), 16'h8);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_ovf", 16'(overflow), 16'h0);

        // Full FIFO with pop in the push cycle accepts the new event
        key_state = 1'b1;
        step();
        key_code = 8'h5A;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        key_state = 1'b0;
        check("full_pop_level", 16'(level), 16'h8);
        check("full_pop_ovf", 16'(overflow), 16'h0);
        step();
        bus.out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("drain_%0d", i), 16'(bus.out_data), 16'(8'h61 + 8'(i)));
            step();
        end
        check("drain_newest", 16'(bus.out_data), 16'h5A);
        step();
        bus.out_ready = 1'b0;
        check("drain_level", 16'(level), 16'h0);

        // Asynchronous reset mid-stream, with overflow set
        for (int i = 0; i < 8; i++) press(8'h31 + 8'(i));
        press(8'h40);
        check("prereset_level", 16'(level), 16'h8);
        check("prereset_ovf", 16'(overflow), 16'h1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 16'(bus.out_valid), 16'h0);
        check("async_rst_level", 16'(level), 16'h0);
        check("async_rst_ovf", 16'(overflow), 16'h0);
        step();
        check("rst_hold_level", 16'(level), 16'h0);
        rst = 1'b1;
        step();
        press(ASCII_0);
        check("post_rst_data", 16'(bus.out_data), 16'h30);
        check("post_rst_level", 16'(level), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
